uart_rx_deser: RTL
==================

// Module: uart_rx_deser
// PURPOSE
//   UART receive deserializer feeding a first-word-fall-through byte FIFO.
//   Consumes the serial line produced by the SimUART DPI bridge (its uart_tx) and
//   presents 8N1 bytes to the debug module's transport layer via valid/ready.
//   Flags framing errors and FIFO overruns as single-cycle pulses.
// PARAMETERS
//   CLKS_PER_BIT  51  clock cycles per UART bit (TICK_DELAY+1 of the bridge); must be >= 4
//   FIFO_DEPTH    4   receive FIFO entries; power of two, >= 2
// PORTS
//   clock       in   1                   system clock, all logic on posedge
//   reset       in   1                   asynchronous, active-high; clears all state
//   uart_rx     in   1                   serial input, idle high, asynchronous to clock
//   rx_data     out  8                   FIFO head byte; valid only while rx_valid=1
//   rx_valid    out  1                   FIFO non-empty
//   rx_ready    in   1                   consumer pops head when rx_valid && rx_ready
//   frame_err   out  1                   1-cycle pulse: stop bit sampled low
//   overrun     out  1                   1-cycle pulse: good byte dropped, FIFO full
//   fifo_count  out  $clog2(FIFO_DEPTH+1) occupied entries
// BEHAVIOUR
// - Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, fifo_count=0;
//   synchronizer flops=1; FSM=IDLE; bit counter=0; FIFO pointers=0.
// - uart_rx passes a 2-flop synchronizer (rx_s); FSM sees only rx_s.
// - Bit timer: down-counter, $clog2(CLKS_PER_BIT) bits; "tick" = counter==0.
// - FSM states and transitions:
//   IDLE:  rx_s==0 -> START, counter=CLKS_PER_BIT/2-1.
//   START: on tick sample rx_s; 0 -> DATA, counter=CLKS_PER_BIT-1, bit_idx=0;
//          1 -> IDLE (glitch rejected, nothing reported).
//   DATA:  on tick shift rx_s in LSB-first, reload counter; after bit_idx 7 -> STOP.
//   STOP:  on tick sample rx_s; 1 -> push byte, -> IDLE;
//          0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK: stay until rx_s==1, then -> IDLE (held-low line gives one frame_err only).
// - Return to IDLE at mid-stop-bit; a start bit arriving right after is detected.
// - Latency: rx_valid rises the cycle after the STOP sample edge (3 cycles after
//   the uart_rx mid-stop-bit edge incl. synchronizer).
// - FIFO: FWFT, rx_data = mem[rd_ptr]; pointers wrap modulo FIFO_DEPTH.
//   pop = rx_valid && rx_ready; push = good stop bit.
//   push accepted if fifo_count<FIFO_DEPTH OR pop in same cycle (full + push + pop:
//   count unchanged, no overrun). Otherwise byte dropped, overrun pulses 1 cycle.
//   Empty + push: rx_valid=1 next cycle. rx_ready while empty is ignored.
//   fifo_count = count + push_ok - pop, never exceeds FIFO_DEPTH.
// - frame_err and overrun are never both high; each is high for exactly one cycle.
// - Reset asserted mid-frame: frame aborted, FIFO flushed, no pulses; after release
//   the line must be seen low again from IDLE to start a frame.
// TESTING
// 1. CLKS_PER_BIT=8, send 0xA5 8N1, rx_ready=0 -> rx_data=0xA5, rx_valid=1 3 cycles
//    after mid-stop-bit, fifo_count=1; rx_ready=1 one cycle -> rx_valid=0, count=0.
// 2. uart_rx low 2 cycles then high (CLKS_PER_BIT=8) -> no push, no frame_err, FSM IDLE.
// 3. Send 0x3C with stop bit 0, then hold line low 20 bit times -> exactly one
//    frame_err pulse, fifo_count=0; release high, send 0x55 -> rx_data=0x55.
// 4. FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> count=4, one overrun on 5th;
//    drain -> 0x01,0x02,0x03,0x04 in order, then rx_valid=0.
// 5. FIFO full, rx_ready=1 asserted exactly on the push cycle -> no overrun,
//    count stays 4, popped 0x01, new byte last in order.
// 6. Assert reset at DATA bit 3 with 2 bytes queued -> outputs at reset values
//    immediately; after release send 0x7E -> rx_data=0x7E, count=1.

Source files
------------

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a
// first-word-fall-through byte FIFO with framing-error and overrun pulses.
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 51,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             uart_rx,
  output logic [7:0]                       rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic                             frame_err,
  output logic                             overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            push_q;
  logic            frame_err_q;
  logic            tick;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic            rx_valid_q;
  logic            overrun_q;
  logic            pop;
  logic            push_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (cnt_q == '0);

  // Stop bit sampled low parks in S_BREAK so a held-low line reports only once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= HALF_LOAD;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s_q) begin
              state_q   <= S_DATA;
              cnt_q     <= BIT_LOAD;
              bit_idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            cnt_q     <= BIT_LOAD;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so full + push + pop is accepted.
  always_comb begin
    pop     = rx_valid_q && rx_ready;
    push_ok = push_q && ((count_q != FULL_CNT) || pop);
    count_d = count_q + CNTW'(push_ok) - CNTW'(pop);
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q    <= count_d;
      rx_valid_q <= (count_d != '0);
      overrun_q  <= push_q && !push_ok;
    end
  end

  assign rx_data    = rx_valid_q ? mem_q[rd_ptr_q] : '0;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign fifo_count = count_q;

endmodule
